key_schedule_ctrl: RTL and testbench
====================================

# key_schedule_ctrl

Sequential AES key-schedule controller that expands a 128/192/256-bit cipher key into NR+1 round keys, one 32-bit word per clock, into an internal word buffer. The iterative cipher round engine then fetches round keys by index over a registered request/response port. It replaces a fully unrolled combinational expansion with a small shared datapath: one SubWord unit and one Rcon generator. It sits between key load and the round engine.

## Interface
- NK, 4, key length in 32-bit words; legal pairs are (4,10), (6,12) and (8,14).
- NR, 10, number of cipher rounds.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- key_in  in  NK*32  cipher key; word 0 occupies the MSBs.
- key_valid  in  1  key offered.
- key_ready  out  1  high in IDLE and READY.
- rk_req  in  1  round-key read request; honoured only in READY.
- rk_idx  in  4  round index 0..NR.
- rk_valid  out  1  one-cycle pulse; read data is valid.
- rk_out  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.
- busy  out  1  high in EXPAND.
- done  out  1  high in READY: all round keys are valid.

## Operation
- FSM states are IDLE, EXPAND and READY. Reset enters IDLE.
- Word buffer: w[0..4*(NR+1)-1], i.e. 44/52/60 words of 32 bits. Word counter i is 6 bits.
- IDLE/READY with key_valid&&key_ready:
  - w[0..NK-1] are loaded from key_in.
  - i is set to NK.
  - rcon is set to 8'h01.
  - The state moves to EXPAND and done clears.
- EXPAND, each cycle:
  - Compute temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), where xtime is a left shift with XOR 8'h1b when bit 7 was set.
  - Else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
  - Then write w[i] = w[i-NK] ^ temp and increment i.
  - When i == 4*(NR+1)-1 is written, go to READY.
- Track i mod NK with a separate wrap counter (0..NK-1). No divider is used.
- RotWord rotates left by one byte. SubWord uses four S-box instances of the codebase's existing S-box.
- READY holds until a new key is accepted. The buffer contents are retained.
- Read port, READY and rk_req:
  - On the next edge rk_valid=1 and rk_out is the selected key.
  - If rk_idx > NR, rk_out = 128'h0 and rk_valid still pulses.
  - rk_req in IDLE or EXPAND is ignored: no rk_valid and rk_out unchanged.
- A new key accepted in READY restarts expansion and drops done on the same edge. A read request on that same edge is ignored.
- key_valid during EXPAND is ignored because key_ready=0. The source must hold the key.
- An illegal NK/NR pair is a static error: simulation reports $error at elaboration.

## Timing
- Reset values: key_ready=1, rk_valid=0, rk_out=0, busy=0, done=0, i=0, rcon=8'h01, state IDLE. Buffer contents are don't-care.
- Accept edge E0. Words w[NK]..w[last] are written on edges E1..E(4(NR+1)-NK).
- done and key_ready rise, and busy falls, at edge E40, E46 or E52 for 128, 192 and 256-bit keys.
- rk_req sampled at edge T gives rk_valid/rk_out at T+1. Back-to-back requests give one result per cycle.
- rk_valid is a single-cycle pulse. rk_out holds its last value until the next read.
- Reset asserted mid-EXPAND returns to IDLE asynchronously with done=0. After release a fresh key is required.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c.
  - done at E40.
  - rk_idx 1 gives a0fafe1788542cb123a339392a6c7605.
  - rk_idx 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_idx 0 returns the key.
- NK=6/NR=12, key 000102...1617: done at E46; rk_idx 12 gives a4970a331a78dc09c418c271e3a41d5d.
- NK=8/NR=14, key 000102...1e1f: done at E52; rk_idx 14 gives 24fc79ccbf0979e9371ac23c6d68de36.
- NK=4, reads:
  - rk_req with rk_idx=11 gives rk_valid=1, rk_out=0.
  - rk_req during EXPAND gives no rk_valid.
  - Reads of idx 0..10 on 11 consecutive cycles give 11 consecutive valid pulses.
- Restart and reset:
  - Drop rst_n at E20 of an expansion: immediately done=0, busy=0, key_ready=1.
  - Reload the first key after release: results are identical to the first test.
  - Load a second key in READY: done drops at the accept edge and returns 40 cycles later with new keys.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// Iterative AES key expansion: one 32-bit word per clock into a word buffer,
// then indexed round-key reads with a one-cycle registered response.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = p;
      for (int k = 0; k < 8; k++) begin
         if (q[k]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // inverse as p^254 via square-and-multiply; 0 maps to 0 as the S-box needs
   function automatic logic [7:0] gf_inv(input logic [7:0] p);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 7; k >= 0; k--) begin
         r = gf_mul(r, r);
         if (k != 0) r = gf_mul(r, p);
      end
      return r;
   endfunction

   logic [7:0] b;
   assign b = gf_inv(a);
   assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module key_schedule_ctrl #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NK*32-1:0] key_in,
   input  logic            key_valid,
   output logic            key_ready,
   input  logic            rk_req,
   input  logic [3:0]      rk_idx,
   output logic            rk_valid,
   output logic [127:0]    rk_out,
   output logic            busy,
   output logic            done
);
   localparam int         NW  = 4 * (NR + 1);
   localparam logic [5:0] NK6 = 6'(NK);
   localparam logic [5:0] LST = 6'(NW - 1);
   localparam logic [2:0] WCM = 3'(NK - 1);
   localparam logic [3:0] NR4 = 4'(NR);

   if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : g_bad_cfg
      $error("key_schedule_ctrl: illegal NK/NR pair");
   end

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t      state;
   logic [31:0] w [NW];
   logic [5:0]  i;
   logic [2:0]  wc;
   logic [7:0]  rcon;

   logic        accept;
   logic [31:0] prev, back, sub_in, sub_out, temp, w_next;
   logic [5:0]  base;
   logic [127:0] rd_data;

   assign accept = key_valid && key_ready;
   assign prev   = w[i - 6'd1];
   assign back   = w[i - NK6];
   assign sub_in = (wc == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

   aes_sbox u_sbox [3:0] (.a(sub_in), .y(sub_out));

   always_comb begin
      temp = prev;
      if (wc == 3'd0)                  temp = sub_out ^ {rcon, 24'h0};
      else if (NK == 8 && wc == 3'd4)  temp = sub_out;
   end
   assign w_next = back ^ temp;

   assign base = {rk_idx, 2'b00};
   always_comb begin
      rd_data = '0;
      if (rk_idx <= NR4)
         rd_data = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
   end

   // buffer holds no reset: contents are only meaningful once done is high
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NK; k++) w[k] <= key_in[(NK-k)*32-1 -: 32];
      end else if (state == EXPAND) begin
         w[i] <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         i         <= 6'd0;
         wc        <= 3'd0;
         rcon      <= 8'h01;
         key_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         rk_valid  <= 1'b0;
         rk_out    <= '0;
      end else begin
         rk_valid <= 1'b0;
         case (state)
            IDLE, READY: begin
               if (accept) begin
                  state     <= EXPAND;
                  i         <= NK6;
                  wc        <= 3'd0;
                  rcon      <= 8'h01;
                  key_ready <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end else if (state == READY && rk_req) begin
                  rk_valid <= 1'b1;
                  rk_out   <= rd_data;
               end
            end
            EXPAND: begin
               i  <= i + 6'd1;
               wc <= (wc == WCM) ? 3'd0 : wc + 3'd1;
               if (wc == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               if (i == LST) begin
                  state     <= READY;
                  key_ready <= 1'b1;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: three configurations against a word-level
// key-expansion model plus the published round-key vectors.

module tb_key_schedule_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         kv [3];
   logic         rq [3];
   logic [3:0]   ri [3];
   logic         kr [3];
   logic         rv [3];
   logic         bz [3];
   logic         dn [3];
   logic [127:0] ro [3];
   logic [127:0] key4;
   logic [191:0] key6;
   logic [255:0] key8;

   key_schedule_ctrl dut4 (
      .clk(clk), .rst_n(rst_n), .key_in(key4), .key_valid(kv[0]), .key_ready(kr[0]),
      .rk_req(rq[0]), .rk_idx(ri[0]), .rk_valid(rv[0]), .rk_out(ro[0]), .busy(bz[0]), .done(dn[0]));
   key_schedule_ctrl #(.NK(6), .NR(12)) dut6 (
      .clk(clk), .rst_n(rst_n), .key_in(key6), .key_valid(kv[1]), .key_ready(kr[1]),
      .rk_req(rq[1]), .rk_idx(ri[1]), .rk_valid(rv[1]), .rk_out(ro[1]), .busy(bz[1]), .done(dn[1]));
   key_schedule_ctrl #(.NK(8), .NR(14)) dut8 (
      .clk(clk), .rst_n(rst_n), .key_in(key8), .key_valid(kv[2]), .key_ready(kr[2]),
      .rk_req(rq[2]), .rk_idx(ri[2]), .rk_valid(rv[2]), .rk_out(ro[2]), .busy(bz[2]), .done(dn[2]));

   int total = 0;
   int bad   = 0;

   logic [7:0]  sb [256];
   logic [31:0] mw [3][60];

   localparam logic [255:0] FIPS4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] FIPS6 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] FIPS8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      int p, x;
      p = 0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = x << 1;
         if (x > 255) x = x ^ 'h11b;
      end
      return 8'(p);
   endfunction

   // S-box from its definition: brute-force field inverse, then the affine map
   task automatic build_sbox();
      logic [7:0] inv, o, cc;
      cc = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int b = 0; b < 8; b++)
            o[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ cc[b];
         sb[x] = o;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   task automatic model_expand(input int d, input logic [255:0] k);
      int nk, nw;
      logic [31:0] t;
      logic [7:0]  rc;
      nk = 4 + 2*d;
      nw = 4 * (10 + 2*d + 1);
      for (int j = 0; j < nk; j++) mw[d][j] = k[255-32*j -: 32];
      for (int j = nk; j < nw; j++) begin
         t = mw[d][j-1];
         if (j % nk == 0) begin
            rc = 8'h01;
            for (int m = 1; m < j / nk; m++) rc = gm(rc, 8'h02);
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk == 8 && j % nk == 4) begin
            t = subw(t);
         end
         mw[d][j] = mw[d][j-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] model_rk(input int d, input int idx);
      if (idx > 10 + 2*d) return 128'h0;
      return {mw[d][4*idx], mw[d][4*idx+1], mw[d][4*idx+2], mw[d][4*idx+3]};
   endfunction

   task automatic accept(input int d, input logic [255:0] k);
      case (d)
         0:       key4 = k[255:128];
         1:       key6 = k[255:64];
         default: key8 = k;
      endcase
      model_expand(d, k);
      kv[d] = 1'b1;
      step();
      kv[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, output int n);
      n = 0;
      while (dn[d] !== 1'b1 && n < 200) begin
         step();
         n++;
      end
   endtask

   task automatic rd(input int d, input int idx, output logic v, output logic [127:0] q);
      rq[d] = 1'b1;
      ri[d] = 4'(idx);
      step();
      rq[d] = 1'b0;
      v = rv[d];
      q = ro[d];
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         total += 5;
         if (kr[d] !== 1'b1) begin bad++; $display("FAIL reset_key_ready d=%0d got=%b exp=1", d, kr[d]); end
         if (rv[d] !== 1'b0) begin bad++; $display("FAIL reset_rk_valid d=%0d got=%b exp=0", d, rv[d]); end
         if (ro[d] !== 128'h0) begin bad++; $display("FAIL reset_rk_out d=%0d got=%h exp=0", d, ro[d]); end
         if (bz[d] !== 1'b0) begin bad++; $display("FAIL reset_busy d=%0d got=%b exp=0", d, bz[d]); end
         if (dn[d] !== 1'b0) begin bad++; $display("FAIL reset_done d=%0d got=%b exp=0", d, dn[d]); end
      end
   endtask

   task automatic test_fips(input int d, input logic [255:0] k, input int vidx, input logic [127:0] vexp);
      int n;
      logic v;
      logic [127:0] q;
      accept(d, k);
      total += 3;
      if (dn[d] !== 1'b0) begin bad++; $display("FAIL accept_done d=%0d got=%b exp=0", d, dn[d]); end
      if (bz[d] !== 1'b1) begin bad++; $display("FAIL accept_busy d=%0d got=%b exp=1", d, bz[d]); end
      if (kr[d] !== 1'b0) begin bad++; $display("FAIL accept_ready d=%0d got=%b exp=0", d, kr[d]); end
      wait_done(d, n);
      total += 3;
      if (n != 4*(11+2*d) - (4+2*d)) begin bad++; $display("FAIL done_edge d=%0d got=%0d exp=%0d", d, n, 4*(11+2*d)-(4+2*d)); end
      if (bz[d] !== 1'b0) begin bad++; $display("FAIL done_busy d=%0d got=%b exp=0", d, bz[d]); end
      if (kr[d] !== 1'b1) begin bad++; $display("FAIL done_ready d=%0d got=%b exp=1", d, kr[d]); end
      rd(d, vidx, v, q);
      total += 2;
      if (v !== 1'b1) begin bad++; $display("FAIL vec_valid d=%0d got=%b exp=1", d, v); end
      if (q !== vexp) begin bad++; $display("FAIL vec_rk d=%0d idx=%0d got=%h exp=%h", d, vidx, q, vexp); end
      for (int x = 0; x <= 10 + 2*d; x++) begin
         rd(d, x, v, q);
         total++;
         if (q !== model_rk(d, x)) begin bad++; $display("FAIL model_rk d=%0d idx=%0d got=%h exp=%h", d, x, q, model_rk(d, x)); end
      end
   endtask

   task automatic test_nk4_vectors();
      logic v;
      logic [127:0] q;
      test_fips(0, FIPS4, 1, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(0, 10, v, q);
      rd(0, 0, v, q);
      total++;
      if (q !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin bad++; $display("FAIL rk0_is_key got=%h", q); end
      rd(0, 10, v, q);
      total++;
      if (q !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin bad++; $display("FAIL rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", q); end
   endtask

   task automatic test_out_of_range();
      logic v;
      logic [127:0] q;
      for (int x = 11; x < 16; x++) begin
         rd(0, x, v, q);
         total += 2;
         if (v !== 1'b1) begin bad++; $display("FAIL oor_valid idx=%0d got=%b exp=1", x, v); end
         if (q !== 128'h0) begin bad++; $display("FAIL oor_data idx=%0d got=%h exp=0", x, q); end
      end
   endtask

   task automatic test_req_in_expand();
      logic [127:0] prev;
      int n;
      prev = ro[0];
      accept(0, FIPS4);
      rq[0] = 1'b1;
      ri[0] = 4'd3;
      for (int c = 0; c < 5; c++) begin
         step();
         total += 2;
         if (rv[0] !== 1'b0) begin bad++; $display("FAIL expand_req_valid cyc=%0d got=%b exp=0", c, rv[0]); end
         if (ro[0] !== prev) begin bad++; $display("FAIL expand_req_hold cyc=%0d got=%h exp=%h", c, ro[0], prev); end
      end
      rq[0] = 1'b0;
      wait_done(0, n);
      total++;
      if (n + 5 != 40) begin bad++; $display("FAIL expand_done_edge got=%0d exp=40", n + 5); end
   endtask

   task automatic test_back_to_back();
      rq[0] = 1'b1;
      for (int x = 0; x <= 10; x++) begin
         ri[0] = 4'(x);
         step();
         total += 2;
         if (rv[0] !== 1'b1) begin bad++; $display("FAIL b2b_valid idx=%0d got=%b exp=1", x, rv[0]); end
         if (ro[0] !== model_rk(0, x)) begin bad++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", x, ro[0], model_rk(0, x)); end
      end
      rq[0] = 1'b0;
      step();
      total += 2;
      if (rv[0] !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", rv[0]); end
      if (ro[0] !== model_rk(0, 10)) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", ro[0], model_rk(0, 10)); end
   endtask

   task automatic test_reload_ready();
      logic [255:0] k;
      logic v;
      logic [127:0] q;
      int n;
      k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      rq[0] = 1'b1;
      ri[0] = 4'd2;
      accept(0, k);
      rq[0] = 1'b0;
      total += 2;
      if (dn[0] !== 1'b0) begin bad++; $display("FAIL reload_done got=%b exp=0", dn[0]); end
      if (rv[0] !== 1'b0) begin bad++; $display("FAIL reload_req_ignored got=%b exp=0", rv[0]); end
      wait_done(0, n);
      total++;
      if (n != 40) begin bad++; $display("FAIL reload_done_edge got=%0d exp=40", n); end
      for (int x = 0; x <= 10; x++) begin
         rd(0, x, v, q);
         total++;
         if (q !== model_rk(0, x)) begin bad++; $display("FAIL reload_rk idx=%0d got=%h exp=%h", x, q, model_rk(0, x)); end
      end
   endtask

   task automatic test_random();
      logic [255:0] k;
      logic v;
      logic [127:0] q;
      int n, nr, t, ord [15];
      for (int d = 0; d < 3; d++) begin
         for (int r = 0; r < 2; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            accept(d, k);
            wait_done(d, n);
            nr = 10 + 2*d;
            total++;
            if (n != 4*(nr+1) - (4+2*d)) begin bad++; $display("FAIL rand_done_edge d=%0d got=%0d", d, n); end
            for (int x = 0; x <= nr; x++) ord[x] = x;
            for (int x = nr; x > 0; x--) begin
               t = $urandom_range(x, 0);
               {ord[x], ord[t]} = {ord[t], ord[x]};
            end
            for (int x = 0; x <= nr; x++) begin
               rd(d, ord[x], v, q);
               total++;
               if (v !== 1'b1 || q !== model_rk(d, ord[x])) begin
                  bad++;
                  $display("FAIL rand_rk d=%0d idx=%0d valid=%b got=%h exp=%h", d, ord[x], v, q, model_rk(d, ord[x]));
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic v;
      logic [127:0] q;
      int n;
      accept(0, FIPS4);
      repeat (20) step();
      rst_n = 1'b0;
      #1;
      total += 3;
      if (dn[0] !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", dn[0]); end
      if (bz[0] !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", bz[0]); end
      if (kr[0] !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", kr[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      total++;
      if (dn[0] !== 1'b0 || bz[0] !== 1'b0) begin bad++; $display("FAIL postreset_idle done=%b busy=%b exp=0", dn[0], bz[0]); end
      accept(0, FIPS4);
      wait_done(0, n);
      total++;
      if (n != 40) begin bad++; $display("FAIL postreset_done_edge got=%0d exp=40", n); end
      rd(0, 1, v, q);
      total++;
      if (q !== 128'ha0fafe1788542cb123a339392a6c7605) begin bad++; $display("FAIL postreset_rk1 got=%h", q); end
      rd(0, 10, v, q);
      total++;
      if (q !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin bad++; $display("FAIL postreset_rk10 got=%h", q); end
   endtask

   initial begin
      rst_n = 1'b0;
      key4 = '0;
      key6 = '0;
      key8 = '0;
      for (int d = 0; d < 3; d++) begin
         kv[d] = 1'b0;
         rq[d] = 1'b0;
         ri[d] = 4'd0;
      end
      build_sbox();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      test_nk4_vectors();
      test_fips(1, FIPS6, 12, 128'ha4970a331a78dc09c418c271e3a41d5d);
      test_fips(2, FIPS8, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      test_out_of_range();
      test_req_in_expand();
      test_back_to_back();
      test_reload_ready();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
